// File: rtl/mackey_glass_lut_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mackey_glass_lut_pipe
// Brief    : 3-stage programmable-table Mackey-Glass nonlinearity with optional
//            linear interpolation between breakpoints and valid/ready streaming.
// Revision : 1.0 - initial release
// ============================================================================
module mackey_glass_lut_pipe #(
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 32,
  parameter int ADDR_W = 8,
  parameter int FRAC_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  din,
  input  logic              interp_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DOUT_W-1:0] dout,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DOUT_W-1:0] cfg_wdata
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PROD_W = DOUT_W + 1 + FRAC_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_IDX  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [DOUT_W-1:0] mem [DEPTH];

  logic              w_stall;
  logic [ADDR_W-1:0] w_idx;
  logic [FRAC_W-1:0] w_frac;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_idx_q;
  logic [FRAC_W-1:0] s1_frac_q;
  logic              s1_interp_q;

  logic              s2_valid_q;
  logic [DOUT_W-1:0] s2_y0_q;
  logic [DOUT_W-1:0] s2_y1_q;
  logic [FRAC_W-1:0] s2_frac_q;
  logic              s2_interp_q;

  logic              out_valid_q;
  logic [DOUT_W-1:0] dout_q;
  logic [DOUT_W-1:0] dout_d;

  logic signed [DOUT_W:0]   w_diff;
  logic signed [PROD_W-1:0] w_diff_x;
  logic signed [PROD_W-1:0] w_frac_x;
  logic signed [PROD_W-1:0] w_prod;
  logic [DOUT_W-1:0]        w_corr;

  assign w_stall   = out_valid_q & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;

  assign w_idx  = din[DIN_W-1 -: ADDR_W];
  assign w_frac = din[DIN_W-ADDR_W-1 -: FRAC_W];

  generate
    if (DIN_W - ADDR_W > FRAC_W) begin : g_unused_lsbs
      logic unused_din_lsbs;
      assign unused_din_lsbs = ^din[DIN_W-ADDR_W-FRAC_W-1:0];
    end
  endgenerate

  // Table write port; reads in the same edge see the pre-write contents.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_frac_q   <= '0;
      s1_interp_q <= 1'b0;
    end else if (!w_stall) begin
      s1_valid_q  <= in_valid;
      s1_idx_q    <= w_idx;
      s1_frac_q   <= w_frac;
      s1_interp_q <= interp_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_y0_q     <= '0;
      s2_y1_q     <= '0;
      s2_frac_q   <= '0;
      s2_interp_q <= 1'b0;
    end else if (!w_stall) begin
      s2_valid_q  <= s1_valid_q;
      s2_y0_q     <= mem[s1_idx_q];
      // Top entry has no right neighbour: clamp instead of wrapping to 0.
      s2_y1_q     <= (s1_idx_q == LAST_IDX) ? mem[s1_idx_q] : mem[s1_idx_q + ONE_IDX];
      s2_frac_q   <= s1_frac_q;
      s2_interp_q <= s1_interp_q;
    end
  end

  assign w_diff   = $signed({1'b0, s2_y1_q}) - $signed({1'b0, s2_y0_q});
  assign w_diff_x = {{FRAC_W{w_diff[DOUT_W]}}, w_diff};
  assign w_frac_x = {{(PROD_W-FRAC_W){1'b0}}, s2_frac_q};
  assign w_prod   = w_diff_x * w_frac_x;
  // Correction lies between 0 and y1-y0, so modular add cannot overflow.
  assign w_corr   = DOUT_W'(w_prod >>> FRAC_W);

  always_comb begin
    dout_d = s2_y0_q;
    if (s2_interp_q) begin
      dout_d = s2_y0_q + w_corr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (!w_stall) begin
      out_valid_q <= s2_valid_q;
      dout_q      <= dout_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mackey_glass_lut_pipe.md
Name: mackey_glass_lut_pipe

Overview:
- Pipelined, run-time-programmable successor to the fixed Mackey-Glass nonlinearity block in the DFR reservoir node datapath.
- Replaces the hard-coded 180-step threshold ladder with a RAM-based table of 2^ADDR_W breakpoints.
- Supports optional linear interpolation between breakpoints and a valid/ready stream handshake.
- Table is loaded over a simple config write port by the host register block.

Parameters:
- DIN_W, 32, input sample width, unsigned.
- DOUT_W, 32, output width, unsigned.
- ADDR_W, 8, table index bits; depth = 2^ADDR_W entries.
- FRAC_W, 12, interpolation fraction bits taken below the index; FRAC_W <= DIN_W-ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- din  in  DIN_W  input sample, unsigned.
- interp_en  in  1  1 = linear interpolation, 0 = step lookup; sampled with each accepted input.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts dout.
- dout  out  DOUT_W  nonlinearity output.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table entry address.
- cfg_wdata  in  DOUT_W  table entry value.

Behaviour:
- Reset: out_valid=0, dout=0, all pipeline valid bits=0; in_ready=1 in the cycle after rst deasserts. Table contents are not cleared by reset.
- Decode:
  - idx = din[DIN_W-1 -: ADDR_W].
  - frac = din[DIN_W-ADDR_W-1 -: FRAC_W]; lower bits are discarded.
- Pipeline, 3 stages, fixed latency 3 cycles from accept to out_valid when unstalled:
  - S1 registers idx, frac, interp_en, valid.
  - S2 reads y0 = table[idx] and y1 = table[idx+1].
    - Index clamp: when idx = 2^ADDR_W-1, y1 = y0; no wrap to entry 0.
  - S3 computes dout:
    - interp_en=0: dout = y0.
    - interp_en=1: dout = y0 + ((y1 - y0) * frac) >>> FRAC_W.
    - Difference is computed signed with DOUT_W+1 bits, product with DOUT_W+1+FRAC_W bits, arithmetic shift, truncating toward negative infinity.
    - Result always lies between y0 and y1 inclusive, so no saturation is needed.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - stall = out_valid & ~out_ready. While stalled, all stages hold, dout is stable, and in_ready = 0.
  - in_ready = ~stall, combinational.
  - Pipeline bubbles propagate normally; a full pipeline sustains 1 sample per cycle with out_ready held at 1.
- Config writes:
  - Accepted every cycle independent of the stream, including during stalls.
  - Read-before-write: an S2 read of the address being written in the same cycle returns the old value; the new value is visible from the next cycle.
  - Simultaneous writes are impossible, since the port is single-write.
- Reset mid-stream: in-flight samples are discarded, with no out_valid pulse afterwards; table contents are preserved.
- Boundaries:
  - din = 0 gives idx 0, frac 0, dout = table[0].
  - din = all-ones gives the last entry; with interpolation, y1 is clamped so dout = table[last].
- Storage: synthesises to distributed or block RAM with two read ports plus one write port. Duplicated RAM is acceptable.

Test Plan:
- Program table[i] = i*16 for i = 0..255, interp_en=0, din=0x0100_0000 -> dout=0x10 exactly 3 cycles after accept, out_valid single pulse.
- Same table, interp_en=1, din=0x0180_0000 (idx 1, frac 0x800) -> dout=0x18; with din=0xFFFF_FFFF -> dout=0xFF0 (clamped).
- Descending segment: table[5]=0x100, table[6]=0x080, interp_en=1, din=0x0540_0000 (frac 0x400) -> dout=0x0E0.
- Stream of 16 consecutive samples with out_ready=1 -> 16 outputs on 16 consecutive cycles, in order. Deassert out_ready for 5 cycles mid-stream -> in_ready=0 and dout constant throughout; no loss or duplication after release.
- cfg_we to table[3] in the same cycle an idx-3 sample is in S2 -> that sample returns the old value, and the next idx-3 sample returns the new value.
- Assert rst with 3 samples in flight -> out_valid=0 and dout=0 the cycle after; table unchanged, so a post-reset lookup of din=0x0100_0000 still returns 0x10.
